// File: rtl/heston_pkg.sv
// Shared definitions for the Heston Monte Carlo pipeline (payoff_calculator,
// payoff_averager and the pricer top).
//   DATA_W   : width of payoffs, discount factor and prices
//   FRAC_W   : fractional bits of the unsigned Q1.31 discount factor
//   DISC_ONE : Q1.31 encoding of 1.0
//   state_e  : run-control states of the averager
package heston_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FRAC_W = 31;

    localparam logic [DATA_W-1:0] DISC_ONE = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/q131_scale_sat.sv
// Combinational unsigned value * Q1.31 factor, result >> FRAC_W, saturated
// to W bits.
//   i_mean    : unsigned value to scale
//   i_disc    : unsigned Q1.31 factor (DISC_ONE = 1.0, up to ~2.0)
//   o_price_c : scaled value, all-ones when it does not fit in W bits
module q131_scale_sat #(
    parameter int unsigned W = heston_pkg::DATA_W
) (
    input  logic [W-1:0] i_mean,
    input  logic [W-1:0] i_disc,
    output logic [W-1:0] o_price_c
);
    import heston_pkg::*;

    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_scaled;

    // Full-width product; the largest operands still fit in 2*W bits.
    assign w_prod   = (2*W)'(i_mean) * (2*W)'(i_disc);
    assign w_scaled = w_prod >> FRAC_W;

    // Any bit above W means the result cannot be represented: clamp.
    assign o_price_c = (|w_scaled[2*W-1:W]) ? '1 : w_scaled[W-1:0];

endmodule

// File: rtl/payoff_averager.sv
// Accumulates 2^LOG2_PATHS per-path payoffs, takes the mean by right shift,
// applies a Q1.31 discount and presents the discounted option price.
//   i_clk, i_rst      : clock, synchronous active-low reset
//   i_start           : begins a run (honoured in IDLE/DONE), latches i_disc
//   i_disc            : Q1.31 discount factor
//   i_payoff_valid/i_payoff, o_payoff_ready : payoff stream handshake
//   o_busy            : run in progress (ACCUM or SCALE)
//   o_path_count      : payoffs accepted in the current or last run
//   o_price, o_price_valid : discounted mean, valid in DONE
module payoff_averager #(
    parameter int unsigned DATA_W     = heston_pkg::DATA_W,
    parameter int unsigned LOG2_PATHS = 10,
    parameter int unsigned ACC_W      = DATA_W + LOG2_PATHS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_disc,
    input  logic                  i_payoff_valid,
    input  logic [DATA_W-1:0]     i_payoff,
    output logic                  o_payoff_ready,
    output logic                  o_busy,
    output logic [LOG2_PATHS:0]   o_path_count,
    output logic [DATA_W-1:0]     o_price,
    output logic                  o_price_valid
);
    import heston_pkg::*;

    localparam logic [LOG2_PATHS:0] LAST_BEAT =
        ((LOG2_PATHS+1)'(1) << LOG2_PATHS) - (LOG2_PATHS+1)'(1);

    state_e                r_state;
    state_e                w_next;
    logic                  w_load;
    logic                  w_accept;
    logic [ACC_W-1:0]      r_acc;
    logic [LOG2_PATHS:0]   r_count;
    logic [DATA_W-1:0]     r_disc;
    logic [DATA_W-1:0]     r_price;
    logic                  r_price_valid;
    logic                  r_ready;
    logic                  r_busy;
    logic [DATA_W-1:0]     w_mean;
    logic [DATA_W-1:0]     w_scaled;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and run-control strobes.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_next = ACCUM;
                end
            end
            ACCUM: begin
                if (i_payoff_valid) begin
                    w_accept = 1'b1;
                    if (r_count == LAST_BEAT) begin
                        w_next = SCALE;
                    end
                end
            end
            SCALE: begin
                w_next = DONE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Truncating mean: drop the LOG2_PATHS fraction bits.
    assign w_mean = DATA_W'(r_acc >> LOG2_PATHS);

    q131_scale_sat #(
        .W (DATA_W)
    ) u_scale (
        .i_mean    (w_mean),
        .i_disc    (r_disc),
        .o_price_c (w_scaled)
    );

    // Datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_acc         <= '0;
            r_count       <= '0;
            r_disc        <= '0;
            r_price       <= '0;
            r_price_valid <= 1'b0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_load) begin
                r_acc         <= '0;
                r_count       <= '0;
                r_disc        <= i_disc;
                r_price       <= '0;
                r_price_valid <= 1'b0;
            end
            if (w_accept) begin
                r_acc   <= r_acc + ACC_W'(i_payoff);
                r_count <= r_count + (LOG2_PATHS+1)'(1);
            end
            if (r_state == SCALE) begin
                r_price       <= w_scaled;
                r_price_valid <= 1'b1;
            end
            // Ready/busy follow the state being entered, so they are flop outputs.
            r_ready <= (w_next == ACCUM);
            r_busy  <= (w_next == ACCUM) || (w_next == SCALE);
        end
    end

    assign o_payoff_ready = r_ready;
    assign o_busy         = r_busy;
    assign o_path_count   = r_count;
    assign o_price        = r_price;
    assign o_price_valid  = r_price_valid;

endmodule

// File: tb/tb_payoff_averager.sv
// Self-checking bench for payoff_averager with LOG2_PATHS=2 (4 paths/run):
// a table of directed runs, reset sequences and randomized runs checked
// against an arithmetic reference model.
module tb_payoff_averager;

    localparam int unsigned L2 = 2;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] disc;
    logic          pvld;
    logic [DW-1:0] pay;
    logic          ready;
    logic          busy;
    logic [L2:0]   pcount;
    logic [DW-1:0] price;
    logic          pval;

    int n_tests = 0;
    int n_fail  = 0;

    payoff_averager #(
        .DATA_W     (DW),
        .LOG2_PATHS (L2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_disc         (disc),
        .i_payoff_valid (pvld),
        .i_payoff       (pay),
        .o_payoff_ready (ready),
        .o_busy         (busy),
        .o_path_count   (pcount),
        .o_price        (price),
        .o_price_valid  (pval)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  d;
        logic [127:0] pays;     // beat i at [32*i +: 32]
        int           gap_pos;  // beat index preceded by a valid-low gap, -1 none
        int           gap_len;
        bit           mid;      // pulse start during the gap
        bit           coll;     // offer a beat together with start
        logic [31:0]  exp;
        int           hold;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: arithmetic mean (truncated) times Q1.31 factor, clamped.
    function automatic logic [31:0] model(input logic [127:0] pays, input logic [31:0] d);
        logic [63:0] sum;
        logic [63:0] mean;
        logic [63:0] sc;
        sum = 64'd0;
        for (int i = 0; i < 4; i++) sum += {32'd0, pays[32*i +: 32]};
        mean = sum / 64'd4;
        sc   = (mean * {32'd0, d}) / 64'h8000_0000;
        if (sc > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return sc[31:0];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "/ready"},  {63'd0, ready}, 64'd0);
        check({tag, "/busy"},   {63'd0, busy},  64'd0);
        check({tag, "/pcount"}, {61'd0, pcount}, 64'd0);
        check({tag, "/price"},  {32'd0, price}, 64'd0);
        check({tag, "/pval"},   {63'd0, pval},  64'd0);
    endtask

    task automatic run(input string tag, input vec_t v);
        int lat;
        start = 1'b1;
        disc  = v.d;
        pvld  = v.coll;
        pay   = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        pvld  = 1'b0;
        disc  = ~v.d;
        check({tag, "/start_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "/start_busy"},  {63'd0, busy},  64'd1);
        check({tag, "/start_cnt"},   {61'd0, pcount}, 64'd0);
        check({tag, "/start_pval"},  {63'd0, pval},  64'd0);
        check({tag, "/start_price"}, {32'd0, price}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == v.gap_pos) begin
                for (int g = 0; g < v.gap_len; g++) begin
                    start = v.mid && (g == 0);
                    pay   = 32'h1234_5678;
                    tick();
                    start = 1'b0;
                    check({tag, "/gap_cnt"}, {61'd0, pcount}, 64'(i));
                end
            end
            pvld = 1'b1;
            pay  = v.pays[32*i +: 32];
            tick();
            pvld = 1'b0;
            check({tag, "/beat_cnt"}, {61'd0, pcount}, 64'(i + 1));
            check({tag, "/beat_ready"}, {63'd0, ready}, (i < 3) ? 64'd1 : 64'd0);
        end
        check({tag, "/scale_busy"}, {63'd0, busy}, 64'd1);
        check({tag, "/scale_pval"}, {63'd0, pval}, 64'd0);
        lat = 0;
        while (!pval && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'd1);
        check({tag, "/price"},   {32'd0, price}, {32'd0, v.exp});
        check({tag, "/cnt"},     {61'd0, pcount}, 64'd4);
        check({tag, "/busy"},    {63'd0, busy},  64'd0);
        check({tag, "/ready"},   {63'd0, ready}, 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check({tag, "/hold_pval"},  {63'd0, pval},  64'd1);
            check({tag, "/hold_price"}, {32'd0, price}, {32'd0, v.exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [127:0] rp;

        tbl[0] = '{32'h8000_0000, {32'd10, 32'd30, 32'd0, 32'd20}, -1, 0, 1'b0, 1'b0, 32'd15, 5};
        tbl[1] = '{32'h4000_0000, {32'd10, 32'd30, 32'd0, 32'd20},  2, 3, 1'b1, 1'b0, 32'd7, 0};
        tbl[2] = '{32'h8000_0000, {4{32'hFFFF_FFFF}}, -1, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0};
        tbl[3] = '{32'hFFFF_FFFF, {4{32'hFFFF_FFFF}}, -1, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0};
        tbl[4] = '{32'h8000_0000, {4{32'd4}}, -1, 0, 1'b0, 1'b1, 32'd4, 0};
        tbl[5] = '{32'h0000_0000, {32'd10, 32'd9, 32'd8, 32'd7}, -1, 0, 1'b0, 1'b0, 32'd0, 0};
        tbl[6] = '{32'h8000_0000, {32'd0, 32'd1, 32'd1, 32'd1}, 1, 1, 1'b0, 1'b0, 32'd0, 0};

        // Reset holds everything low even with start and valid asserted.
        rst   = 1'b0;
        start = 1'b1;
        pvld  = 1'b1;
        pay   = 32'd5;
        disc  = 32'hFFFF_FFFF;
        tick();
        tick();
        check_idle("reset");
        rst   = 1'b1;
        start = 1'b0;
        pvld  = 1'b0;
        tick();
        check_idle("post_reset");

        // Directed table; runs after the first start from DONE back to back.
        for (int k = 0; k < 7; k++) begin
            run($sformatf("vec%0d", k), tbl[k]);
        end

        // Reset from DONE clears the held price.
        rst = 1'b0;
        tick();
        check_idle("reset_done");
        rst = 1'b1;
        tick();

        // Reset mid-run: partial accumulation must not leak into the next run.
        start = 1'b1;
        disc  = 32'h8000_0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pvld = 1'b1;
            pay  = 32'd999;
            tick();
        end
        pvld = 1'b0;
        rst  = 1'b0;
        tick();
        check_idle("reset_mid");
        rst = 1'b1;
        tick();
        check_idle("after_mid");
        v = '{32'h8000_0000, {4{32'd100}}, -1, 0, 1'b0, 1'b0, 32'd100, 0};
        run("hundreds", v);

        // Randomized runs against the reference model.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) begin
                rp[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom;
            end
            v.d       = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            v.pays    = rp;
            v.gap_pos = $urandom_range(0, 4);
            v.gap_len = $urandom_range(0, 3);
            v.mid     = $urandom_range(0, 1) == 1;
            v.coll    = $urandom_range(0, 1) == 1;
            v.exp     = model(rp, v.d);
            v.hold    = $urandom_range(0, 2);
            run($sformatf("rand%0d", r), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
